// File: rtl/vm_change_dispenser.sv
// vm_change_dispenser: greedy largest-coin-first change return with per-denomination stock tracking.
module vm_change_dispenser #(
  parameter int NUM_COINS  = 3,
  parameter int COIN_VAL0  = 100,
  parameter int COIN_VAL1  = 500,
  parameter int COIN_VAL2  = 1000,
  parameter int BAL_W      = 32,
  parameter int STOCK_W    = 8,
  parameter int STOCK_INIT = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         i_start,
  input  logic [BAL_W-1:0]             i_balance,
  input  logic [NUM_COINS-1:0]         i_input_coin,
  output logic [NUM_COINS-1:0]         o_return_coin,
  output logic                         o_busy,
  output logic                         o_done,
  output logic [BAL_W-1:0]             o_remainder,
  output logic [NUM_COINS*STOCK_W-1:0] o_stock
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t r_state, w_next;
  logic [BAL_W-1:0] r_rem, w_val;
  logic [STOCK_W-1:0] r_stock [NUM_COINS];
  logic [NUM_COINS-1:0] w_pick, w_dec;
  logic w_any;
  function automatic logic [BAL_W-1:0] coin_val(input int k);
    return k == 2 ? BAL_W'(COIN_VAL2) : k == 1 ? BAL_W'(COIN_VAL1) : BAL_W'(COIN_VAL0);
  endfunction
  // Later (larger) eligible coins overwrite earlier ones, so the highest wins.
  always_comb begin
    w_pick = '0;
    w_any  = 1'b0;
    w_val  = '0;
    for (int k = 0; k < NUM_COINS; k++)
      if (r_rem >= coin_val(k) && r_stock[k] != '0) begin
        w_pick    = '0;
        w_pick[k] = 1'b1;
        w_any     = 1'b1;
        w_val     = coin_val(k);
      end
  end
  assign w_dec = (r_state == RUN) ? w_pick : '0;
  always_comb begin
    w_next = (r_state == IDLE) ? (i_start ? RUN : IDLE) :
             (r_state == RUN)  ? (w_any ? RUN : DONE) : IDLE;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_rem   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && i_start)
        r_rem <= i_balance;
      else if (r_state == RUN && w_any)
        r_rem <= r_rem - w_val;
    end
  end
  // Simultaneous insert and dispense of one coin cancel out.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_COINS; k++) r_stock[k] <= STOCK_W'(STOCK_INIT);
    end else begin
      for (int k = 0; k < NUM_COINS; k++)
        if (i_input_coin[k] && !w_dec[k] && r_stock[k] != '1)
          r_stock[k] <= r_stock[k] + 1'b1;
        else if (w_dec[k] && !i_input_coin[k])
          r_stock[k] <= r_stock[k] - 1'b1;
    end
  end
  always_comb begin
    o_stock = '0;
    for (int k = 0; k < NUM_COINS; k++) o_stock[k*STOCK_W +: STOCK_W] = r_stock[k];
  end
  assign o_return_coin = w_dec;
  assign o_busy        = (r_state != IDLE);
  assign o_done        = (r_state == DONE);
  assign o_remainder   = r_rem;
endmodule

// File: tb/tb_vm_change_dispenser.sv
// tb_vm_change_dispenser: directed-vector bench for the change dispenser.
module tb_vm_change_dispenser;
  logic        clk = 0, reset_n = 0, i_start = 0;
  logic [31:0] i_balance = '0;
  logic [2:0]  i_input_coin = '0, o_return_coin;
  logic        o_busy, o_done;
  logic [31:0] o_remainder;
  logic [23:0] o_stock;
  int checks = 0, errors = 0;

  vm_change_dispenser dut (
    .clk(clk), .reset_n(reset_n), .i_start(i_start), .i_balance(i_balance),
    .i_input_coin(i_input_coin), .o_return_coin(o_return_coin), .o_busy(o_busy),
    .o_done(o_done), .o_remainder(o_remainder), .o_stock(o_stock)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_seq(input logic [31:0] bal, input int e0, e1, e2, input logic [31:0] erem);
    int c0 = 0, c1 = 0, c2 = 0;
    bit got = 0;
    i_balance = bal; i_start = 1;
    @(negedge clk);
    i_start = 0;
    for (int n = 0; n < 40 && !got; n++) begin
      c0 += int'(o_return_coin[0]);
      c1 += int'(o_return_coin[1]);
      c2 += int'(o_return_coin[2]);
      if (o_done) begin
        got = 1;
        check("seq_rem", o_remainder, erem);
      end else @(negedge clk);
    end
    check("seq_done_seen", 32'(got), 32'd1);
    check("seq_c0", 32'(c0), 32'(e0));
    check("seq_c1", 32'(c1), 32'(e1));
    check("seq_c2", 32'(c2), 32'(e2));
    @(negedge clk);
    check("seq_idle", 32'(o_busy), 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_coin", 32'(o_return_coin), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_stock", 32'(o_stock), 32'h080808);
    reset_n = 1;
    @(negedge clk);
    // 1600 with full stock: 1000, 500, 100, empty, done
    i_balance = 1600; i_start = 1;
    @(negedge clk); i_start = 0;
    check("t1_c1", 32'(o_return_coin), 32'b100);
    check("t1_busy", 32'(o_busy), 32'd1);
    @(negedge clk); check("t1_c2", 32'(o_return_coin), 32'b010);
    @(negedge clk); check("t1_c3", 32'(o_return_coin), 32'b001);
    @(negedge clk); check("t1_c4", 32'(o_return_coin), 32'b000);
    check("t1_nodone", 32'(o_done), 32'd0);
    @(negedge clk);
    check("t1_done", 32'(o_done), 32'd1);
    check("t1_rem", o_remainder, 32'd0);
    check("t1_stock", 32'(o_stock), 32'h070707);
    @(negedge clk);
    check("t1_idle", 32'(o_done | o_busy), 32'd0);
    // drain coin 2, then 1000 must come back as two 500s
    run_seq(7000, 0, 0, 7, 0);
    check("t2a_stock", 32'(o_stock), 32'h000707);
    run_seq(1000, 0, 2, 0, 0);
    check("t2_stock", 32'(o_stock), 32'h000507);
    // leave only one coin 0
    run_seq(2500, 0, 5, 0, 0);
    run_seq(600, 6, 0, 0, 0);
    check("t3a_stock", 32'(o_stock), 32'h000001);
    run_seq(350, 1, 0, 0, 250);
    check("t3_stock", 32'(o_stock), 32'h000000);
    // zero balance
    i_balance = 0; i_start = 1;
    @(negedge clk); i_start = 0;
    check("t4_run_coin", 32'(o_return_coin), 32'd0);
    check("t4_run_busy", 32'(o_busy), 32'd1);
    check("t4_run_nodone", 32'(o_done), 32'd0);
    @(negedge clk);
    check("t4_done", 32'(o_done), 32'd1);
    check("t4_rem", o_remainder, 32'd0);
    check("t4_stock", 32'(o_stock), 32'h000000);
    @(negedge clk);
    // async reset mid-sequence after refill by insertion
    i_input_coin = 3'b100;
    @(negedge clk); i_input_coin = 0;
    check("ins_stock", 32'(o_stock), 32'h010000);
    i_balance = 1600; i_start = 1;
    @(negedge clk); i_start = 0;
    check("t6_first", 32'(o_return_coin), 32'b100);
    #2 reset_n = 0;
    #1;
    check("t6_rst_coin", 32'(o_return_coin), 32'd0);
    check("t6_rst_busy", 32'(o_busy), 32'd0);
    check("t6_rst_rem", o_remainder, 32'd0);
    check("t6_rst_stock", 32'(o_stock), 32'h080808);
    @(negedge clk); reset_n = 1;
    @(negedge clk);
    i_balance = 500; i_start = 1;
    @(negedge clk); i_start = 0;
    check("t6_c1", 32'(o_return_coin), 32'b010);
    @(negedge clk); check("t6_c2", 32'(o_return_coin), 32'b000);
    @(negedge clk); check("t6_done", 32'(o_done), 32'd1);
    check("t6_stock", 32'(o_stock), 32'h080708);
    @(negedge clk);
    // start while busy and insert coin 1 as coin 1 is dispensed
    i_balance = 1500; i_start = 1;
    @(negedge clk); i_start = 0;
    check("t5_c1", 32'(o_return_coin), 32'b100);
    @(negedge clk);
    check("t5_c2", 32'(o_return_coin), 32'b010);
    i_start = 1; i_balance = 5000; i_input_coin = 3'b010;
    @(negedge clk);
    i_start = 0; i_input_coin = 0;
    check("t5_c3", 32'(o_return_coin), 32'b000);
    check("t5_stock_mid", 32'(o_stock), 32'h070708);
    @(negedge clk);
    check("t5_done", 32'(o_done), 32'd1);
    check("t5_rem", o_remainder, 32'd0);
    @(negedge clk);
    check("t5_idle", 32'(o_busy), 32'd0);
    // multi-bit insertion
    i_input_coin = 3'b111;
    @(negedge clk); i_input_coin = 0;
    check("multi_ins", 32'(o_stock), 32'h080809);
    // saturation of coin 0
    i_input_coin = 3'b001;
    repeat (260) @(negedge clk);
    i_input_coin = 0;
    check("sat_stock", 32'(o_stock), 32'h0808FF);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
